// File: rtl/hazard_ctrl_if.sv
// Decode-side bundle between the decode/control logic and hazard_ctrl.
// The decode/control logic drives the instruction fields through the master
// modport. hazard_ctrl drives the forwarding selects, stall/issue and the
// regfile write port through the slave modport.
interface hazard_ctrl_if #(
  parameter int NUM_SRC    = 2,
  parameter int REG_ADDR_W = 5,
  parameter int SEL_W      = 2,
  parameter int CNT_W      = 32
);
  logic                          dec_valid;
  logic [NUM_SRC*REG_ADDR_W-1:0] dec_rs;
  logic [NUM_SRC-1:0]            dec_rs_used;
  logic [REG_ADDR_W-1:0]         dec_rd;
  logic                          dec_we;
  logic [SEL_W-1:0]              dec_rdy;
  logic                          flush;
  logic                          cnt_clr;
  logic [NUM_SRC*SEL_W-1:0]      fwd_sel;
  logic                          stall;
  logic                          issue;
  logic                          wb_we;
  logic [REG_ADDR_W-1:0]         wb_rd;
  logic [CNT_W-1:0]              stall_count;

  modport master (
    output dec_valid, dec_rs, dec_rs_used, dec_rd, dec_we, dec_rdy, flush, cnt_clr,
    input  fwd_sel, stall, issue, wb_we, wb_rd, stall_count
  );

  modport slave (
    input  dec_valid, dec_rs, dec_rs_used, dec_rd, dec_we, dec_rdy, flush, cnt_clr,
    output fwd_sel, stall, issue, wb_we, wb_rd, stall_count
  );
endinterface

// File: rtl/hazard_ctrl.sv
// Hazard and forwarding controller for the in-order Riscv151 pipeline family.
// It tracks each issued instruction through DEPTH post-decode slots. Slot 0
// follows decode and slot DEPTH-1 is writeback. For every source operand it
// picks a forwarding source, and it stalls decode while the youngest producer
// of an operand has not reached the slot where its result becomes available.
module hazard_ctrl #(
  parameter int DEPTH      = 3,
  parameter int NUM_SRC    = 2,
  parameter int REG_ADDR_W = 5,
  parameter int CNT_W      = 32,
  localparam int SEL_W     = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          reset_n,
  hazard_ctrl_if.slave  bus
);

  typedef struct packed {
    logic                  valid;
    logic                  we;
    logic [REG_ADDR_W-1:0] rd;
    logic [SEL_W-1:0]      rdy;  // slot index where the result is first on the bypass bus
  } slot_t;

  localparam logic [SEL_W-1:0] LAST_SLOT = SEL_W'(DEPTH - 1);

  slot_t                    slot_q [DEPTH];
  logic [CNT_W-1:0]         stall_cnt_q;

  logic [REG_ADDR_W-1:0]    rs       [NUM_SRC];
  logic [NUM_SRC-1:0]       hit;
  logic [SEL_W-1:0]         hit_slot [NUM_SRC];
  logic [SEL_W-1:0]         hit_rdy  [NUM_SRC];
  logic [NUM_SRC-1:0]       op_wait;
  logic [NUM_SRC*SEL_W-1:0] fwd_sel;
  logic                     stall;
  logic                     issue;
  logic [SEL_W-1:0]         rdy_eff;
  slot_t                    new_slot;

  // Split the packed source-address bus into one address per operand.
  for (genvar g = 0; g < NUM_SRC; g++) begin : g_rs
    assign rs[g] = bus.dec_rs[g*REG_ADDR_W +: REG_ADDR_W];
  end

  // Per operand: find the youngest matching producer and decide forward or wait.
  always_comb begin
    // NOTE: every output of this block gets a default before the loops, so no path leaves one unassigned and no latch is inferred.
    hit     = '0;
    op_wait = '0;
    fwd_sel = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      hit_slot[i] = '0;
      hit_rdy[i]  = '0;
      // NOTE: blocking assignments let the scan run oldest to youngest, so the youngest match is the last one written and wins.
      for (int k = DEPTH - 1; k >= 0; k--) begin
        if (bus.dec_rs_used[i] && slot_q[k].valid && slot_q[k].we &&
            slot_q[k].rd == rs[i] && rs[i] != '0) begin
          hit[i]      = 1'b1;
          hit_slot[i] = SEL_W'(k);
          hit_rdy[i]  = slot_q[k].rdy;
        end
      end
      if (hit[i]) begin
        if (hit_slot[i] >= hit_rdy[i]) begin
          fwd_sel[i*SEL_W +: SEL_W] = hit_slot[i] + SEL_W'(1);
        end else begin
          op_wait[i] = 1'b1;
        end
      end
    end
  end

  // A flush drops the decode instruction, so it also suppresses the stall.
  assign stall = reset_n & bus.dec_valid & ~bus.flush & (|op_wait);
  assign issue = reset_n & bus.dec_valid & ~bus.flush & ~stall;

  // Readiness beyond the last slot is treated as ready at writeback.
  assign rdy_eff = (bus.dec_rdy > LAST_SLOT) ? LAST_SLOT : bus.dec_rdy;

  // Slot 0 gets the decode instruction when it issues, otherwise a bubble.
  always_comb begin
    new_slot = '0;
    if (issue) begin
      new_slot.valid = 1'b1;
      new_slot.we    = bus.dec_we;
      new_slot.rd    = bus.dec_rd;
      new_slot.rdy   = rdy_eff;
    end
  end

  // The slot pipeline shifts every cycle and never stalls.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      // NOTE: the slots are cleared in full, not just the valid bits, so wb_rd reads 0 after reset.
      for (int k = 0; k < DEPTH; k++) begin
        slot_q[k] <= '0;
      end
    end else begin
      slot_q[0] <= new_slot;
      for (int k = 1; k < DEPTH; k++) begin
        slot_q[k] <= slot_q[k-1];
      end
    end
  end

  // Count stall cycles, saturating at all-ones. A clear takes priority.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      stall_cnt_q <= '0;
    end else if (bus.cnt_clr) begin
      stall_cnt_q <= '0;
    end else if (stall && stall_cnt_q != '1) begin
      stall_cnt_q <= stall_cnt_q + CNT_W'(1);
    end
  end

  assign bus.fwd_sel     = fwd_sel;
  assign bus.stall       = stall;
  assign bus.issue       = issue;
  assign bus.wb_we       = reset_n & slot_q[DEPTH-1].valid & slot_q[DEPTH-1].we &
                           (slot_q[DEPTH-1].rd != '0);
  assign bus.wb_rd       = slot_q[DEPTH-1].rd;
  assign bus.stall_count = stall_cnt_q;

endmodule
